// File: rtl/csi2_rx_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module : csi2_rx_capture_ctrl
// Frame-aligned capture gate with line/frame geometry checks for csi2_rx video.
// Rev    : 1.0  initial release
// ============================================================================

module csi2_rx_capture_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int PX_CNT_WIDTH    = 12,
    parameter int LINE_CNT_WIDTH  = 12,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       px_clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       single_shot_i,
    input  logic [PX_CNT_WIDTH-1:0]    line_px_i,
    input  logic [LINE_CNT_WIDTH-1:0]  frame_lines_i,
    input  logic                       err_clr_i,
    output logic                       rx_enable_o,
    output logic                       busy_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
    output logic                       short_line_err_o,
    output logic                       long_line_err_o,
    output logic                       sof_err_o,
    input  logic [DATA_WIDTH-1:0]      s_tdata_i,
    input  logic                       s_tvalid_i,
    input  logic                       s_tuser_i,
    input  logic                       s_tlast_i,
    output logic                       s_tready_o,
    output logic [DATA_WIDTH-1:0]      m_tdata_o,
    output logic                       m_tvalid_o,
    output logic                       m_tuser_o,
    output logic                       m_tlast_o,
    input  logic                       m_tready_i
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_sof = 2'd1;
    localparam logic [1:0] c_st_stream   = 2'd2;
    localparam logic [1:0] c_st_discard  = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [PX_CNT_WIDTH-1:0]    line_px_q, line_px_d;
    logic [LINE_CNT_WIDTH-1:0]  frame_lines_q, frame_lines_d;
    logic                       single_shot_q, single_shot_d;
    logic [PX_CNT_WIDTH-1:0]    px_cnt_q, px_cnt_d;
    logic [LINE_CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       stop_pending_q, stop_pending_d;
    logic                       short_err_q, short_err_d;
    logic                       long_err_q, long_err_d;
    logic                       sof_err_q, sof_err_d;

    logic                       w_fwd;
    logic                       w_beat;
    logic                       w_proc;
    logic [PX_CNT_WIDTH-1:0]    w_px_base;
    logic [PX_CNT_WIDTH-1:0]    w_px_inc;
    logic [LINE_CNT_WIDTH-1:0]  w_line_base;
    logic [LINE_CNT_WIDTH-1:0]  w_line_inc;
    logic                       w_at_len;
    logic                       w_long;
    logic                       w_short;
    logic                       w_line_end;
    logic                       w_frame_end;

    // A tuser beat is always pixel 0 of line 0, whatever the counters held.
    assign w_px_base   = s_tuser_i ? '0 : px_cnt_q;
    assign w_line_base = s_tuser_i ? '0 : line_cnt_q;
    assign w_px_inc    = w_px_base + PX_CNT_WIDTH'(1);
    assign w_line_inc  = w_line_base + LINE_CNT_WIDTH'(1);
    assign w_at_len    = (w_px_inc == line_px_q);
    assign w_long      = ~s_tlast_i & w_at_len;
    assign w_short     = s_tlast_i & ~w_at_len;
    assign w_line_end  = s_tlast_i | w_at_len;
    assign w_frame_end = w_line_end & (w_line_inc == frame_lines_q);
    assign w_beat      = s_tvalid_i & s_tready_o;
    assign w_proc      = w_beat & w_fwd;

    assign m_tdata_o        = s_tdata_i;
    assign m_tuser_o        = s_tuser_i;
    assign frame_cnt_o      = frame_cnt_q;
    assign short_line_err_o = short_err_q;
    assign long_line_err_o  = long_err_q;
    assign sof_err_o        = sof_err_q;

    always_ff @(posedge px_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= c_st_idle;
            line_px_q      <= '0;
            frame_lines_q  <= '0;
            single_shot_q  <= 1'b0;
            px_cnt_q       <= '0;
            line_cnt_q     <= '0;
            frame_cnt_q    <= '0;
            stop_pending_q <= 1'b0;
            short_err_q    <= 1'b0;
            long_err_q     <= 1'b0;
            sof_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_px_q      <= line_px_d;
            frame_lines_q  <= frame_lines_d;
            single_shot_q  <= single_shot_d;
            px_cnt_q       <= px_cnt_d;
            line_cnt_q     <= line_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            stop_pending_q <= stop_pending_d;
            short_err_q    <= short_err_d;
            long_err_q     <= long_err_d;
            sof_err_q      <= sof_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        line_px_d      = line_px_q;
        frame_lines_d  = frame_lines_q;
        single_shot_d  = single_shot_q;
        px_cnt_d       = px_cnt_q;
        line_cnt_d     = line_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        stop_pending_d = stop_pending_q;
        short_err_d    = short_err_q & ~err_clr_i;
        long_err_d     = long_err_q & ~err_clr_i;
        sof_err_d      = sof_err_q & ~err_clr_i;

        case (state_q)
            c_st_idle: begin
                if (start_i) begin
                    line_px_d     = line_px_i;
                    frame_lines_d = frame_lines_i;
                    single_shot_d = single_shot_i;
                    state_d       = c_st_wait_sof;
                end
            end
            c_st_wait_sof: begin
                if (stop_i) begin
                    state_d        = c_st_idle;
                    stop_pending_d = 1'b0;
                end
            end
            default: begin
                if (stop_i) begin
                    stop_pending_d = 1'b1;
                end
                // The real tlast of an over-long line only closes the discard window.
                if (state_q == c_st_discard && w_beat && !w_fwd && s_tlast_i) begin
                    state_d = c_st_stream;
                end
            end
        endcase

        if (w_proc) begin
            if (s_tuser_i && state_q != c_st_wait_sof) begin
                sof_err_d = 1'b1;
            end
            if (w_short) begin
                short_err_d = 1'b1;
            end
            if (w_long) begin
                long_err_d = 1'b1;
            end
            px_cnt_d = w_line_end ? '0 : w_px_inc;
            if (w_frame_end) begin
                line_cnt_d  = '0;
                frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                if (single_shot_q || stop_pending_q || stop_i) begin
                    state_d        = c_st_idle;
                    stop_pending_d = 1'b0;
                end else begin
                    state_d = c_st_wait_sof;
                end
            end else begin
                line_cnt_d = w_line_end ? w_line_inc : w_line_base;
                state_d    = w_long ? c_st_discard : c_st_stream;
            end
        end
    end

    always_comb begin
        w_fwd = 1'b0;
        case (state_q)
            c_st_idle:     w_fwd = 1'b0;
            c_st_wait_sof: w_fwd = s_tuser_i & ~stop_i;
            c_st_stream:   w_fwd = 1'b1;
            default:       w_fwd = s_tuser_i;
        endcase
        rx_enable_o = (state_q != c_st_idle);
        busy_o      = (state_q != c_st_idle);
        s_tready_o  = w_fwd ? m_tready_i : 1'b1;
        m_tvalid_o  = w_fwd & s_tvalid_i;
        m_tlast_o   = s_tlast_i | (w_fwd & w_long);
    end

endmodule

`default_nettype wire

// File: doc/csi2_rx_capture_ctrl.md
Name: csi2_rx_capture_ctrl

Overview:
Capture controller between the csi2_rx video output and the downstream pixel pipeline, in the px_clk_i domain. It drives the receiver enable, discards partial frames so that only whole frames starting at SOF (tuser) are forwarded, and checks line and frame geometry against configured sizes. It supports continuous and single-shot capture, a graceful stop at a frame boundary, sticky error flags and a frame counter.

Parameters:
DATA_WIDTH, 16, video tdata width
PX_CNT_WIDTH, 12, width of the pixels-per-line count/config
LINE_CNT_WIDTH, 12, width of the lines-per-frame count/config
FRAME_CNT_WIDTH, 16, width of the frame counter

Ports:
px_clk_i  in  1  pixel clock; the only clock
rst_n_i  in  1  asynchronous reset, active low
start_i  in  1  one-cycle pulse: begin capture
stop_i  in  1  one-cycle pulse: stop at the next frame boundary
single_shot_i  in  1  1 = capture exactly one frame; sampled with start_i
line_px_i  in  PX_CNT_WIDTH  pixels (beats) per line, >=1; sampled with start_i
frame_lines_i  in  LINE_CNT_WIDTH  lines per frame, >=1; sampled with start_i
err_clr_i  in  1  clears all sticky error flags
rx_enable_o  out  1  enable for csi2_rx
busy_o  out  1  state != IDLE
frame_cnt_o  out  FRAME_CNT_WIDTH  completed frames since reset; wraps
short_line_err_o  out  1  sticky: tlast before line_px beats
long_line_err_o  out  1  sticky: line_px beats without tlast
sof_err_o  out  1  sticky: tuser seen mid-frame
s_tdata_i / s_tvalid_i / s_tuser_i / s_tlast_i  in  DATA_WIDTH/1/1/1  stream from csi2_rx
s_tready_o  out  1  ready to csi2_rx
m_tdata_o / m_tvalid_o / m_tuser_o / m_tlast_o  out  DATA_WIDTH/1/1/1  gated stream downstream
m_tready_i  in  1  downstream ready

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; rx_enable_o=0, busy_o=0, frame_cnt_o=0, all error flags=0, counters=0, stop_pending=0.
- Beat = s_tvalid_i & s_tready_o. There is no buffering. m_tdata_o = s_tdata_i and m_tuser_o = s_tuser_i always. Zero latency.
- IDLE: s_tready_o=1 (drain), m_tvalid_o=0, rx_enable_o=0. On start_i: latch line_px, frame_lines and single_shot; go to WAIT_SOF.
- WAIT_SOF: rx_enable_o=1.
  - Beats without tuser: s_tready_o=1, m_tvalid_o=0, beat discarded.
  - Beat with tuser: s_tready_o=m_tready_i, m_tvalid_o=s_tvalid_i, beat forwarded. Set px_cnt=1, line_cnt=0, then go to STREAM. If line_px=1, the line-end rules below apply to this beat.
  - stop_i in WAIT_SOF goes straight to IDLE.
- STREAM: rx_enable_o=1; s_tready_o=m_tready_i; m_tvalid_o=s_tvalid_i. On each beat:
  - tuser=1: set sof_err_o; restart the frame with this beat as pixel 0 of line 0 (px_cnt=1, line_cnt=0). No frame is counted.
  - tlast=1 with px_cnt+1 != line_px: set short_line_err_o. The line ends; counting continues.
  - tlast=0 with px_cnt+1 == line_px: set long_line_err_o. Force m_tlast_o=1 on this beat. The line ends. Subsequent beats up to the real tlast are discarded: s_tready_o=1, m_tvalid_o=0. The discarded tlast beat does not end a further line.
  - Otherwise m_tlast_o = s_tlast_i.
  - Line end: px_cnt=0, line_cnt+1.
  - Frame end: the line end where line_cnt+1 == frame_lines. Then frame_cnt_o increments on the next edge (wraps). If single_shot or stop_pending: go to IDLE and clear stop_pending. Otherwise go to WAIT_SOF.
- stop_i in STREAM sets stop_pending. The current frame completes normally.
- start_i outside IDLE is ignored.
- err_clr_i clears the flags. If it coincides with a new error on the same edge, the set wins.
- Simultaneous stop_i and frame end: IDLE on that edge.
- No handshake is broken while a beat is stalled: m_tvalid_o and the forwarded data follow s_* unchanged until m_tready_i is high.
- Sticky flags persist across IDLE/start cycles until cleared or reset.

Test Plan:
1. Normal frame: start with line_px=4, frame_lines=3, continuous; send 2 junk beats, then SOF plus 3 lines of 4 beats (tlast on beat 4) -> junk dropped; 12 beats forwarded with m_tuser on the first and m_tlast on beats 4/8/12; frame_cnt_o=1; state back to WAIT_SOF; rx_enable_o stays 1.
2. Single-shot with backpressure: as in 1 but single_shot=1 and m_tready_i toggling 1/0 -> no beats lost or duplicated; s_tready_o mirrors m_tready_i; after 12 accepted beats the block is IDLE with rx_enable_o=0, busy_o=0.
3. Short line: line 1 has tlast on beat 3 -> short_line_err_o=1; the frame still completes after 3 lines (11 beats); frame_cnt_o increments; err_clr_i pulse -> flag 0.
4. Long line: line 0 has 6 beats with tlast on beat 6 -> m_tlast_o on beat 4; beats 5-6 dropped; long_line_err_o=1.
5. Mid-frame SOF: tuser on beat 6 of frame -> sof_err_o=1; counting restarts; frame_cnt_o increments only after 12 further beats counted from that SOF.
6. Stop and reset: stop_i mid-frame -> the frame completes, then IDLE; a second run with rst_n_i low mid-frame -> all outputs return to reset values immediately (async), m_tvalid_o=0.
